// File: rtl/control_fsm_decoder.sv
// Multi-cycle control FSM: accepts one instruction per handshake and drives datapath strobes per phase.
// Optional retired-instruction counter is built only when CTRL_RETIRE_CNT_EN is defined.
module control_fsm_decoder #(
    parameter int TIPO_W      = 2,
    parameter int OP_W        = 2,
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [TIPO_W-1:0]  tipo,
    input  logic [OP_W-1:0]    op,
    input  logic               Inm,
    input  logic               zero_in,
    input  logic               mem_ready,
    output logic               RegWrite,
    output logic               ALUSrc,
    output logic               MemWrite,
    output logic               MemRead,
    output logic               ResultSrc,
    output logic               Branch,
    output logic               PCWrite,
    output logic               Link,
    output logic               FlagWrite,
    output logic [1:0]         ImmSrc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               z_flag,
    output logic               illegal_instr,
    output logic               mem_error,
    output logic [CNT_W-1:0]   retired_count
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [ALUOP_W-1:0] ALU_PASS  = '0;
    localparam logic [ALUOP_W-1:0] ALU_CMP   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_ARITH = ALUOP_W'(2);

    localparam logic [1:0] IMM_DATA   = 2'b00;
    localparam logic [1:0] IMM_MEMORY = 2'b01;
    localparam logic [1:0] IMM_BRANCH = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [TIPO_W-1:0]   tipo_q, tipo_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic                inm_q, inm_d;
    logic                z_q, z_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                retire;

    // Instruction class decode from the latched fields.
    logic is_arith, is_xfer, is_flow;
    logic is_mov, is_ldr, is_str;
    logic is_b, is_bl, is_cmp, is_beq;
    logic is_illegal;
    logic mem_timed_out;

    assign is_arith   = (tipo_q == TIPO_W'(0));
    assign is_xfer    = (tipo_q == TIPO_W'(1));
    assign is_flow    = (tipo_q == TIPO_W'(2));
    assign is_mov     = is_xfer && (op_q == OP_W'(0));
    assign is_ldr     = is_xfer && (op_q == OP_W'(1));
    assign is_str     = is_xfer && (op_q == OP_W'(2));
    assign is_b       = is_flow && (op_q == OP_W'(0));
    assign is_bl      = is_flow && (op_q == OP_W'(1));
    assign is_cmp     = is_flow && (op_q == OP_W'(2));
    assign is_beq     = is_flow && (op_q == OP_W'(3));
    assign is_illegal = !(is_arith || is_xfer || is_flow) ||
                        (is_xfer && (op_q == OP_W'(3)));

    // A zero timeout disables the watchdog entirely.
    assign mem_timed_out = (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(MEM_TIMEOUT));

    assign z_flag = z_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            tipo_q  <= '0;
            op_q    <= '0;
            inm_q   <= 1'b0;
            z_q     <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            tipo_q  <= tipo_d;
            op_q    <= op_d;
            inm_q   <= inm_d;
            z_q     <= z_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        tipo_d        = tipo_q;
        op_d          = op_q;
        inm_d         = inm_q;
        z_d           = z_q;
        wait_d        = wait_q;
        retire        = 1'b0;
        instr_ready   = 1'b0;
        RegWrite      = 1'b0;
        ALUSrc        = 1'b0;
        MemWrite      = 1'b0;
        MemRead       = 1'b0;
        ResultSrc     = 1'b0;
        Branch        = 1'b0;
        PCWrite       = 1'b0;
        Link          = 1'b0;
        FlagWrite     = 1'b0;
        ImmSrc        = IMM_DATA;
        ALUOp         = ALU_PASS;
        illegal_instr = 1'b0;
        mem_error     = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    tipo_d  = tipo;
                    op_d    = op;
                    inm_d   = Inm;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                if (is_illegal) begin
                    illegal_instr = 1'b1;
                    state_d       = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                if (is_arith) begin
                    ALUOp   = ALU_ARITH;
                    ALUSrc  = inm_q;
                    state_d = S_WB;
                end else if (is_mov) begin
                    ALUSrc  = inm_q;
                    state_d = S_WB;
                end else if (is_ldr || is_str) begin
                    ALUSrc  = 1'b1;
                    ImmSrc  = IMM_MEMORY;
                    wait_d  = '0;
                    state_d = S_MEM;
                end else begin
                    // Control-flow instructions complete here.
                    Branch    = is_b || is_bl || is_beq;
                    ImmSrc    = (is_b || is_bl || is_beq) ? IMM_BRANCH : IMM_DATA;
                    PCWrite   = is_b || is_bl || (is_beq && z_q);
                    Link      = is_bl;
                    RegWrite  = is_bl;
                    FlagWrite = is_cmp;
                    ALUOp     = is_cmp ? ALU_CMP : ALU_PASS;
                    if (is_cmp) begin
                        z_d = zero_in;
                    end
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_MEM: begin
                // Completion takes priority over a timeout on the same cycle.
                if (mem_ready) begin
                    MemRead  = is_ldr;
                    MemWrite = is_str;
                    wait_d   = '0;
                    retire   = !is_ldr;
                    state_d  = is_ldr ? S_WB : S_FETCH;
                end else if (mem_timed_out) begin
                    mem_error = 1'b1;
                    wait_d    = '0;
                    state_d   = S_FETCH;
                end else begin
                    MemRead  = is_ldr;
                    MemWrite = is_str;
                    if (MEM_TIMEOUT != 0) begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
            end

            S_WB: begin
                RegWrite  = 1'b1;
                ResultSrc = is_ldr;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

`ifdef CTRL_RETIRE_CNT_EN
    logic [CNT_W-1:0] retired_q, retired_d;

    assign retired_d = retire ? (retired_q + CNT_W'(1)) : retired_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired_count = retired_q;
`else
    logic unused_retire;

    assign unused_retire = retire;
    assign retired_count = '0;
`endif

endmodule

// File: tb/tb_control_fsm_decoder.sv
// Self-checking bench for control_fsm_decoder: directed scenarios followed by random instructions,
// each compared cycle by cycle against a phase-list model of the instruction's behaviour.
module tb_control_fsm_decoder;

    localparam int TMO = 3;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_valid;
    logic          instr_ready;
    logic [1:0]    tipo;
    logic [1:0]    op;
    logic          Inm;
    logic          zero_in;
    logic          mem_ready;
    logic          RegWrite, ALUSrc, MemWrite, MemRead, ResultSrc;
    logic          Branch, PCWrite, Link, FlagWrite;
    logic [1:0]    ImmSrc;
    logic [1:0]    ALUOp;
    logic          z_flag;
    logic          illegal_instr;
    logic          mem_error;
    logic [CW-1:0] retired_count;

    control_fsm_decoder #(
        .TIPO_W(2), .OP_W(2), .ALUOP_W(2), .MEM_TIMEOUT(TMO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .tipo(tipo), .op(op), .Inm(Inm),
        .zero_in(zero_in), .mem_ready(mem_ready),
        .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemWrite(MemWrite), .MemRead(MemRead),
        .ResultSrc(ResultSrc), .Branch(Branch), .PCWrite(PCWrite), .Link(Link),
        .FlagWrite(FlagWrite), .ImmSrc(ImmSrc), .ALUOp(ALUOp),
        .z_flag(z_flag), .illegal_instr(illegal_instr), .mem_error(mem_error),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rdy, rw, asrc, mw, mr, rsrc, br, pcw, lnk, fw;
        logic [1:0] imm, aop;
        logic       ill, merr;
    } ctl_t;

    ctl_t          exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    logic          z_model;
    logic          z_next;
    logic [CW-1:0] ret_model;
    bit            exp_retire;

    function automatic ctl_t cur();
        ctl_t c;
        c.rdy  = instr_ready;  c.rw   = RegWrite;  c.asrc = ALUSrc;
        c.mw   = MemWrite;     c.mr   = MemRead;   c.rsrc = ResultSrc;
        c.br   = Branch;       c.pcw  = PCWrite;   c.lnk  = Link;
        c.fw   = FlagWrite;    c.imm  = ImmSrc;    c.aop  = ALUOp;
        c.ill  = illegal_instr; c.merr = mem_error;
        return c;
    endfunction

    function automatic ctl_t idle();
        ctl_t c = '0;
        c.rdy = 1'b1;
        return c;
    endfunction

    function automatic logic [CW-1:0] exp_count();
`ifdef CTRL_RETIRE_CNT_EN
        return ret_model;
`else
        return '0;
`endif
    endfunction

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Expected per-cycle outputs after acceptance, phrased as the instruction's phase list.
    task automatic build(input int t, input int o, input bit inm, input bit zin, input int w);
        ctl_t c;
        bit   ld;
        exp_q.delete();
        exp_retire = 0;
        z_next     = z_model;
        if (t >= 3 || (t == 1 && o == 3)) begin
            c = '0; c.ill = 1'b1; exp_q.push_back(c);
            return;
        end
        c = '0; exp_q.push_back(c);
        c = '0;
        if (t == 0 || (t == 1 && o == 0)) begin
            c.asrc = inm;
            c.aop  = (t == 0) ? 2'd2 : 2'd0;
            exp_q.push_back(c);
            c = '0; c.rw = 1'b1; exp_q.push_back(c);
            exp_retire = 1;
        end else if (t == 1) begin
            ld = (o == 1);
            c.asrc = 1'b1; c.imm = 2'd1; exp_q.push_back(c);
            for (int j = 0; j < 100; j++) begin
                c = '0;
                if (j >= w) begin
                    c.mr = ld; c.mw = !ld; exp_q.push_back(c);
                    if (ld) begin
                        c = '0; c.rw = 1'b1; c.rsrc = 1'b1; exp_q.push_back(c);
                    end
                    exp_retire = 1;
                    break;
                end else if (TMO != 0 && j == TMO) begin
                    c.merr = 1'b1; exp_q.push_back(c);
                    break;
                end else begin
                    c.mr = ld; c.mw = !ld; exp_q.push_back(c);
                end
            end
        end else begin
            case (o)
                0: begin c.br = 1; c.pcw = 1; c.imm = 2'd2; end
                1: begin c.br = 1; c.pcw = 1; c.imm = 2'd2; c.lnk = 1; c.rw = 1; end
                2: begin c.aop = 2'd1; c.fw = 1; z_next = zin; end
                default: begin c.br = 1; c.imm = 2'd2; c.pcw = z_model; end
            endcase
            exp_q.push_back(c);
            exp_retire = 1;
        end
    endtask

    task automatic run(input string tag, input int t, input int o, input bit inm, input bit zin, input int w);
        int n;
        build(t, o, inm, zin, w);
        n = exp_q.size();
        instr_valid = 1'b1; tipo = 2'(t); op = 2'(o); Inm = inm;
        zero_in = zin; mem_ready = 1'b0;
        @(posedge clk); #1;
        // Fields change while busy; the block must ignore them.
        instr_valid = 1'($urandom); tipo = 2'($urandom); op = 2'($urandom); Inm = 1'($urandom);
        for (int k = 0; k < n; k++) begin
            mem_ready = (k >= 2 + w);
            @(negedge clk);
            chk(tag, k, 32'(cur()), 32'(exp_q[k]));
            @(posedge clk); #1;
        end
        instr_valid = 1'b0; mem_ready = 1'b0;
        z_model = z_next;
        if (exp_retire) ret_model = ret_model + 1'b1;
        @(negedge clk);
        chk({tag, "_done"}, n, 32'(cur()), 32'(idle()));
        chk({tag, "_z"}, n, 32'(z_flag), 32'(z_model));
        chk({tag, "_cnt"}, n, 32'(retired_count), 32'(exp_count()));
        $display("%s: tipo=%0d op=%0d inm=%0d zin=%0d w=%0d latency=%0d retired=%0d",
                 tag, t, o, inm, zin, w, n, retired_count);
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; tipo = '0; op = '0; Inm = 1'b0;
        zero_in = 1'b0; mem_ready = 1'b0; z_model = 1'b0; ret_model = '0;
        #2;
        chk("in_reset", 0, 32'(cur()), 32'(idle()));
        chk("in_reset_z", 0, 32'(z_flag), 32'(0));
        chk("in_reset_cnt", 0, 32'(retired_count), 32'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset", 0, 32'(cur()), 32'(idle()));

        run("add_imm", 0, 0, 1, 0, 0);
        run("ldr_w2", 1, 1, 0, 0, 2);
        run("str_timeout", 1, 2, 0, 0, 99);
        run("ldr_timeout", 1, 1, 1, 1, 99);
        run("cmp_z1", 2, 2, 0, 1, 0);
        run("beq_taken", 2, 3, 0, 0, 0);
        run("cmp_z0", 2, 2, 1, 0, 0);
        run("beq_not", 2, 3, 1, 1, 0);
        run("illegal_t3", 3, 0, 0, 0, 0);
        run("illegal_x3", 1, 3, 1, 0, 0);
        run("str_edge", 1, 2, 1, 0, TMO);
        run("ldr_w0", 1, 1, 0, 0, 0);
        run("b", 2, 0, 0, 0, 0);
        run("bl", 2, 1, 1, 0, 0);
        run("mov_reg", 1, 0, 0, 0, 0);
        run("sub_reg", 0, 1, 0, 0, 0);

        // Reset in the middle of an LDR memory wait.
        run("cmp_set", 2, 2, 0, 1, 0);
        instr_valid = 1'b1; tipo = 2'd1; op = 2'd1; Inm = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1; instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mem_before", 0, 32'(MemRead), 32'(1));
        #1 rst = 1'b1;
        #1;
        chk("rst_async", 0, 32'(cur()), 32'(idle()));
        @(posedge clk); #1;
        rst = 1'b0; z_model = 1'b0; ret_model = '0;
        @(negedge clk);
        chk("rst_after", 0, 32'(cur()), 32'(idle()));
        chk("rst_after_z", 0, 32'(z_flag), 32'(0));
        chk("rst_after_cnt", 0, 32'(retired_count), 32'(0));

        for (int i = 0; i < 40; i++) begin
            run("rand", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), int'($urandom_range(0, TMO + 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/control_fsm_decoder.md
# control_fsm_decoder

Multi-cycle successor to the combinational main decoder: it accepts one instruction (tipo/op/Inm) per handshake, sequences it through DECODE, EXEC, MEM and WB states, and drives the datapath control strobes one phase at a time. It also adds:
- a registered Zero flag, so BEQ is resolved internally;
- a variable-latency memory handshake with timeout;
- illegal-encoding detection.

It sits between the instruction register and the datapath/data-memory interface.

## Interface
- TIPO_W, 2, width of the instruction-class field
- OP_W, 2, width of the operation field
- ALUOP_W, 2, width of ALUOp (codes 00 pass/none, 01 compare, 10 arithmetic; upper bits zero)
- MEM_TIMEOUT, 15, max cycles waiting for mem_ready (0 = wait forever)
- CNT_W, 32, retired-instruction counter width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  tipo/op/Inm valid
- instr_ready  out  1  block can accept an instruction (high only in FETCH)
- tipo  in  TIPO_W  instruction class (0 arith, 1 transfer, 2 flow, others illegal)
- op  in  OP_W  operation within class
- Inm  in  1  immediate operand select
- zero_in  in  1  ALU zero result
- mem_ready  in  1  data memory completed the access
- RegWrite, ALUSrc, MemWrite, MemRead, ResultSrc, Branch, PCWrite, Link, FlagWrite  out  1 each  control strobes
- ImmSrc  out  2  immediate format (00 data, 01 memory, 10 branch)
- ALUOp  out  ALUOP_W  ALU control
- z_flag  out  1  registered Zero flag
- illegal_instr  out  1  one-cycle pulse, undecodable instruction
- mem_error  out  1  one-cycle pulse, memory timeout
- retired_count  out  CNT_W  completed instructions

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB. The encoding is local to the block.
- **FETCH**
  - instr_ready=1.
  - On instr_valid, tipo/op/Inm are latched into internal registers and the state moves to DECODE.
  - Inputs are ignored while not in FETCH.
- **DECODE**
  - Illegal encodings: tipo≥3, or tipo=1 with op=3.
  - Illegal → illegal_instr=1 for this cycle, next state FETCH, no strobes asserted.
  - Legal → EXEC.
- **EXEC**, by class:
  - Arith: ALUOp=10, ALUSrc=latched Inm, ImmSrc=00 → WB.
  - MOV (1/0): ALUSrc=Inm, ALUOp=00 → WB.
  - LDR/STR (1/1, 1/2): ALUSrc=1, ImmSrc=01, ALUOp=00 (address calc) → MEM.
  - B (2/0): Branch=1, PCWrite=1, ImmSrc=10 → FETCH.
  - BL (2/1): the B strobes plus Link=1 and RegWrite=1 → FETCH.
  - CMP (2/2): ALUOp=01, FlagWrite=1; z_flag←zero_in at the clock edge → FETCH.
  - BEQ (2/3): Branch=1, ImmSrc=10; PCWrite=z_flag (z_flag as it stands at entry to EXEC) → FETCH.
- **MEM**
  - MemRead (LDR) or MemWrite (STR) is held high until mem_ready is sampled high.
  - On mem_ready: LDR → WB; STR → FETCH.
  - A wait counter counts cycles spent in MEM without mem_ready. When it reaches MEM_TIMEOUT (nonzero): mem_error=1 for one cycle, strobes drop, next state FETCH, no WB.
- **WB**
  - RegWrite=1; ResultSrc=1 for LDR, 0 otherwise → FETCH.
- Retirement:
  - An instruction retires on its exit to FETCH, unless it was illegal or timed out.
  - retired_count increments by 1 and wraps modulo 2^CNT_W.
- All strobes are decoded from the current state and the latched fields. Any strobe not listed for a state is 0.

## Timing
- Reset (async): state=FETCH, z_flag=0, wait counter=0, retired_count=0, latched fields=0.
  - Outputs during and after reset: all strobes 0, illegal_instr=0, mem_error=0, instr_ready=1.
- Latency counts cycles from the accepting edge back to instr_ready=1:
  - Arith/MOV: 3 (DECODE, EXEC, WB).
  - CMP/B/BL/BEQ: 2.
  - Illegal: 1.
  - LDR: 4+w, where w = cycles with mem_ready low.
  - STR: 3+w.
- mem_ready high on the first MEM cycle → w=0.
- mem_ready high on the same cycle the counter hits MEM_TIMEOUT → completion wins, no error.
- CMP immediately followed by BEQ uses the new flag (z_flag is updated at the CMP EXEC edge).
- Reset asserted mid-instruction aborts it with no retirement. Strobes deassert asynchronously.

## Configuration
- CTRL_RETIRE_CNT_EN:
  - Defined → the retired-instruction counter is built as described.
  - Undefined → no counter register; retired_count is tied to 0.

## Test plan
- Reset, then ADD with Inm=1 → instr_ready low for 3 cycles; the EXEC cycle shows ALUOp=10 and ALUSrc=1; then one WB cycle with RegWrite=1 and ResultSrc=0; retired_count=1.
- LDR with mem_ready low 2 cycles, high on the 3rd → MemRead high for 3 cycles, then WB with RegWrite=1 and ResultSrc=1; total latency 6.
- STR with MEM_TIMEOUT=3 and mem_ready held low → MemWrite high 3 cycles, mem_error pulses once, return to FETCH, retired_count unchanged.
- CMP with zero_in=1, then BEQ → z_flag=1 and BEQ EXEC shows PCWrite=1; repeat with zero_in=0 → PCWrite=0 and Branch=1.
- tipo=3 and transfer op=3 → illegal_instr one-cycle pulse after 1 cycle, no strobes, no retirement.
- rst asserted during LDR MEM → MemRead drops immediately; after release: instr_ready=1, z_flag=0, retired_count=0.
